corretor_hamming: RTL and testbench

Pipelined Hamming(15,11) single-error-correcting decoder with valid/ready handshakes on both sides. It sits downstream of the channel and error-injection path, and recovers the 11 data bits from each 15-bit codeword. It reports the syndrome and whether a correction was applied. It optionally keeps a saturating count of corrected words.

---
 rtl/corretor_hamming.sv | 100 ++++++++++
 tb/tb_corretor_hamming.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/corretor_hamming.sv
// Two-stage Hamming(15,11) single-error-correcting decoder with valid/ready on both sides.
// Define CORRETOR_CONTADOR_EN to build the saturating corrected-word counter on contagem.
module corretor_hamming #(
    parameter int LARGURA_CONT = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [14:0]             entrada,
    input  logic                    entrada_valida,
    output logic                    entrada_pronta,
    output logic [10:0]             dados,
    output logic [3:0]              sindrome,
    output logic                    erro,
    output logic                    saida_valida,
    input  logic                    saida_pronta,
    output logic [LARGURA_CONT-1:0] contagem
);

    logic        v1_q, v2_q;
    logic [14:0] palavra_q;
    logic [3:0]  sind1_q, sind1_d;
    logic [10:0] dados_q, dados_d;
    logic [3:0]  sind2_q;
    logic        erro_q, erro_d;
    logic        avanca1, avanca2;
    logic [14:0] mascara, corrigida;

    assign avanca2        = !v2_q || saida_pronta;
    assign avanca1        = !v1_q || avanca2;
    assign entrada_pronta = avanca1;

    // sindrome[k] collects every received bit whose 1-based position has bit k set
    always_comb begin
        sind1_d = '0;
        for (int i = 0; i < 15; i++) begin
            for (int k = 0; k < 4; k++) begin
                if ((((i + 1) >> k) & 1) == 1)
                    sind1_d[k] = sind1_d[k] ^ entrada[i];
            end
        end
    end

    // A nonzero syndrome is the 1-based position of the flipped bit
    always_comb begin
        mascara = '0;
        if (sind1_q != 4'd0)
            mascara = 15'd1 << (sind1_q - 4'd1);
        corrigida = palavra_q ^ mascara;
        dados_d   = {corrigida[14:8], corrigida[6:4], corrigida[2]};
        erro_d    = (sind1_q != 4'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            palavra_q <= '0;
            sind1_q   <= '0;
        end else if (avanca1) begin
            v1_q      <= entrada_valida;
            palavra_q <= entrada;
            sind1_q   <= sind1_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            dados_q <= '0;
            sind2_q <= '0;
            erro_q  <= 1'b0;
        end else if (avanca2) begin
            v2_q    <= v1_q;
            dados_q <= dados_d;
            sind2_q <= sind1_q;
            erro_q  <= erro_d;
        end
    end

    assign dados        = dados_q;
    assign sindrome     = sind2_q;
    assign erro         = erro_q;
    assign saida_valida = v2_q;

`ifdef CORRETOR_CONTADOR_EN
    logic [LARGURA_CONT-1:0] cont_q;

    // Counts delivered corrections only; holds at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cont_q <= '0;
        else if (v2_q && saida_pronta && erro_q && (cont_q != '1))
            cont_q <= cont_q + 1'b1;
    end

    assign contagem = cont_q;
`else
    assign contagem = '0;
`endif

endmodule

// File: tb/tb_corretor_hamming.sv
// Directed, table-driven bench for corretor_hamming: per-vector decode and latency,
// backpressure, full-rate streaming, mid-stream reset and counter saturation.
module tb_corretor_hamming;

    localparam int LC = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [14:0]   entrada = '0;
    logic          entrada_valida = 1'b0;
    logic          entrada_pronta;
    logic [10:0]   dados;
    logic [3:0]    sindrome;
    logic          erro;
    logic          saida_valida;
    logic          saida_pronta = 1'b1;
    logic [LC-1:0] contagem;

    logic          ep_s;
    logic [10:0]   dados_s;
    logic [3:0]    sind_s;
    logic          erro_s;
    logic          sv_s;
    logic [1:0]    cont_s;

    corretor_hamming #(.LARGURA_CONT(LC)) dut (
        .clk(clk), .rst_n(rst_n), .entrada(entrada), .entrada_valida(entrada_valida),
        .entrada_pronta(entrada_pronta), .dados(dados), .sindrome(sindrome), .erro(erro),
        .saida_valida(saida_valida), .saida_pronta(saida_pronta), .contagem(contagem)
    );

    // Narrow-counter copy on the same stimulus, used for the saturation check
    corretor_hamming #(.LARGURA_CONT(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .entrada(entrada), .entrada_valida(entrada_valida),
        .entrada_pronta(ep_s), .dados(dados_s), .sindrome(sind_s), .erro(erro_s),
        .saida_valida(sv_s), .saida_pronta(saida_pronta), .contagem(cont_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] ent;
        logic [10:0] dad;
        logic [3:0]  sin;
        logic        er;
    } vec_t;

    vec_t        tv[26];
    int          n_tests = 0;
    int          n_fail = 0;
    int unsigned exp_cnt = 0;
    int unsigned exp_sat = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic bump(input logic er);
`ifdef CORRETOR_CONTADOR_EN
        if (er && exp_cnt < (2 ** LC) - 1) exp_cnt++;
        if (er && exp_sat < 3) exp_sat++;
`else
        if (er) begin
            exp_cnt = 0;
            exp_sat = 0;
        end
`endif
    endtask

    // Streams n table words starting at tv[first]; saida_pronta is held low for the
    // first 'stall' cycles. Checks every delivered word in order against the table.
    task automatic run_stream(input int first, input int n, input int stall, input string tag);
        int sent = 0, recv = 0, cyc = 0;
        int first_in = -1, first_out = -1, last_out = -1;
        logic in_x, out_x;
        while (recv < n && cyc < 200) begin
            @(negedge clk);
            saida_pronta   = (cyc >= stall);
            entrada_valida = (sent < n);
            if (sent < n) entrada = tv[first + sent].ent;
            #1;
            in_x  = entrada_valida && entrada_pronta;
            out_x = saida_valida && saida_pronta;
            if (stall > 0 && cyc >= 2 && cyc < stall) begin
                chk({tag, " stall accepts"}, sent, 2);
                chk({tag, " stall entrada_pronta"}, entrada_pronta, 0);
                chk({tag, " stall saida_valida"}, saida_valida, 1);
                chk({tag, " stall dados"}, dados, tv[first].dad);
                chk({tag, " stall sindrome"}, sindrome, tv[first].sin);
            end
            if (out_x) begin
                chk({tag, " dados"}, dados, tv[first + recv].dad);
                chk({tag, " sindrome"}, sindrome, tv[first + recv].sin);
                chk({tag, " erro"}, erro, tv[first + recv].er);
                bump(tv[first + recv].er);
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                recv++;
            end
            if (in_x && first_in < 0) first_in = cyc;
            @(posedge clk);
            if (in_x) sent++;
            cyc++;
        end
        @(negedge clk);
        entrada_valida = 1'b0;
        saida_pronta   = 1'b1;
        chk({tag, " delivered"}, recv, n);
        if (stall == 0) begin
            chk({tag, " latency"}, first_out - first_in, 2);
            chk({tag, " back-to-back"}, last_out - first_out, n - 1);
        end
        for (int j = 0; j < 3; j++) begin
            #1;
            chk({tag, " no extra word"}, saida_valida, 0);
            @(negedge clk);
        end
        chk({tag, " contagem"}, contagem, exp_cnt);
    endtask

    initial begin
        tv[0]  = '{15'h0000, 11'h000, 4'd0, 1'b0};
        tv[1]  = '{15'h7FFF, 11'h7FF, 4'd0, 1'b0};
        for (int i = 0; i < 15; i++)
            tv[2 + i] = '{15'h7FFF ^ (15'd1 << i), 11'h7FF, 4'(i + 1), 1'b1};
        tv[17] = '{15'h0007, 11'h001, 4'd0, 1'b0};
        tv[18] = '{15'h0019, 11'h002, 4'd0, 1'b0};
        tv[19] = '{15'h408B, 11'h400, 4'd0, 1'b0};
        tv[20] = '{15'h0181, 11'h010, 4'd0, 1'b0};
        tv[21] = '{15'h001E, 11'h003, 4'd0, 1'b0};
        tv[22] = '{15'h410A, 11'h410, 4'd0, 1'b0};
        tv[23] = '{15'h0407, 11'h001, 4'd11, 1'b1};
        tv[24] = '{15'h008B, 11'h400, 4'd15, 1'b1};
        tv[25] = '{15'h0001, 11'h000, 4'd1, 1'b1};

        #12;
        chk("reset saida_valida", saida_valida, 0);
        chk("reset dados", dados, 0);
        chk("reset sindrome", sindrome, 0);
        chk("reset erro", erro, 0);
        chk("reset contagem", contagem, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++)
            run_stream(i, 1, 0, $sformatf("vec%0d", i));

        run_stream(17, 4, 6, "backpressure");
        run_stream(17, 8, 0, "fullrate");

        // Fill both stages under stall, then reset asynchronously mid-cycle
        @(negedge clk);
        saida_pronta   = 1'b0;
        entrada_valida = 1'b1;
        entrada        = tv[23].ent;
        @(posedge clk);
        @(negedge clk);
        entrada = tv[24].ent;
        @(posedge clk);
        @(negedge clk);
        entrada_valida = 1'b0;
        #1;
        chk("pre-reset full", saida_valida, 1);
        chk("pre-reset entrada_pronta", entrada_pronta, 0);
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        exp_sat = 0;
        chk("async reset saida_valida", saida_valida, 0);
        chk("async reset contagem", contagem, 0);
        chk("async reset dados", dados, 0);
        chk("async reset erro", erro, 0);
        @(negedge clk);
        rst_n        = 1'b1;
        saida_pronta = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            chk("post-reset no stale word", saida_valida, 0);
            @(negedge clk);
        end

        for (int k = 0; k < 5; k++) begin
            run_stream(2 + k, 1, 0, $sformatf("sat%0d", k));
            chk($sformatf("saturating contagem %0d", k), cont_s, exp_sat);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
